// File: rtl/aes_state_io.sv
// Column-wise loader/unloader for the AES 4x4 state matrix: accepts a 128-bit block,
// writes it as four columns, hands off to the round core, then reads four columns back.
module aes_state_io #(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    output logic [31:0]  mat_col_in,
    output logic [1:0]   mat_input_idx,
    output logic         mat_input_row_col,
    output logic         mat_write_enable,
    output logic [1:0]   mat_output_idx,
    output logic         mat_output_row_col,
    input  logic [31:0]  mat_out,
    output logic         proc_start,
    input  logic         proc_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         err
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PROC,
        UNLOAD,
        HOLD
    } state_t;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t         state_q, state_d;
    logic [1:0]     k_q, k_d;
    logic [127:0]   blk_q;
    logic [127:0]   out_q;
    logic           err_q;
    logic           first_q;
    logic [TW-1:0]  tcnt_q;

    logic           accept;
    logic           capture;
    logic           timeout;
    logic           expire;

    // The matrix port always works in column mode.
    assign mat_input_row_col  = 1'b1;
    assign mat_output_row_col = 1'b1;
    assign out_block          = out_q;
    assign err                = err_q;

    assign expire = (TIMEOUT_CYCLES > 0) && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d          = state_q;
        k_d              = k_q;
        in_ready         = 1'b0;
        mat_write_enable = 1'b0;
        mat_input_idx    = 2'd0;
        mat_col_in       = 32'd0;
        mat_output_idx   = 2'd0;
        proc_start       = 1'b0;
        out_valid        = 1'b0;
        accept           = 1'b0;
        capture          = 1'b0;
        timeout          = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    k_d     = 2'd0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                mat_write_enable = 1'b1;
                mat_input_idx    = k_q;
                mat_col_in       = 32'(blk_q >> (7'd96 - {k_q, 5'd0}));
                k_d              = k_q + 2'd1;
                if (k_q == 2'd3) state_d = PROC;
            end
            PROC: begin
                proc_start = first_q;
                // proc_done is masked on the start cycle; it may be stale from the last run.
                if (!first_q) begin
                    if (proc_done) begin
                        k_d     = 2'd0;
                        state_d = UNLOAD;
                    end else if (expire) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            UNLOAD: begin
                mat_output_idx = k_q;
                capture        = 1'b1;
                k_d            = k_q + 2'd1;
                if (k_q == 2'd3) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            blk_q   <= '0;
            out_q   <= '0;
            err_q   <= 1'b0;
            first_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
            k_q     <= k_d;
            first_q <= (state_d == PROC) && (state_q != PROC);

            if (accept) blk_q <= in_block;

            if (accept)       err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;

            if (state_q != PROC || first_q)  tcnt_q <= '0;
            else if (TIMEOUT_CYCLES > 0)     tcnt_q <= tcnt_q + 1'b1;

            if (capture) begin
                unique case (k_q)
                    2'd0: out_q[127:96] <= mat_out;
                    2'd1: out_q[95:64]  <= mat_out;
                    2'd2: out_q[63:32]  <= mat_out;
                    2'd3: out_q[31:0]   <= mat_out;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_state_io.sv
// Directed bench for aes_state_io: behavioural state matrix with an optional read mask,
// round core emulated by driving proc_done from the test tasks.
module tb_aes_state_io;

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_block;
    logic [31:0]  mat_col_in;
    logic [1:0]   mat_input_idx;
    logic         mat_input_row_col;
    logic         mat_write_enable;
    logic [1:0]   mat_output_idx;
    logic         mat_output_row_col;
    logic [31:0]  mat_out;
    logic         proc_start;
    logic         proc_done;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_block;
    logic         err;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [4];
    logic [31:0] xor_mask;

    aes_state_io #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_block           (in_block),
        .mat_col_in         (mat_col_in),
        .mat_input_idx      (mat_input_idx),
        .mat_input_row_col  (mat_input_row_col),
        .mat_write_enable   (mat_write_enable),
        .mat_output_idx     (mat_output_idx),
        .mat_output_row_col (mat_output_row_col),
        .mat_out            (mat_out),
        .proc_start         (proc_start),
        .proc_done          (proc_done),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_block          (out_block),
        .err                (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mat_write_enable) mem[mat_input_idx] <= mat_col_in;
    end
    assign mat_out = mem[mat_output_idx] ^ xor_mask;

    // Present a block at a falling edge and return at the falling edge after the accept.
    task automatic accept_block(input logic [127:0] b);
        int t;
        t = 0;
        in_block = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++; n_err++;
            $display("FAIL accept_wait in_ready=%b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_block = '0;
    endtask

    // Full transaction with proc_done one cycle after proc_start; ends parked in HOLD.
    task automatic run_block(input logic [127:0] b, output int start_n, output int vld_n);
        start_n = -1;
        vld_n   = -1;
        accept_block(b);
        for (int n = 1; n <= 14; n++) begin
            if (proc_start === 1'b1 && start_n < 0) start_n = n;
            proc_done = (start_n > 0 && n == start_n + 1);
            if (out_valid === 1'b1 && vld_n < 0) vld_n = n;
            @(negedge clk);
        end
        proc_done = 1'b0;
    endtask

    task automatic release_hold();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_block  = '0;
        proc_done = 1'b0;
        out_ready = 1'b0;
        xor_mask  = 32'd0;
        #3;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        n_cmp++; if (mat_write_enable !== 1'b0) begin n_err++; $display("FAIL rst_we got=%b want=0", mat_write_enable); end
        n_cmp++; if (mat_input_row_col !== 1'b1 || mat_output_row_col !== 1'b1) begin n_err++; $display("FAIL rst_row_col got=%b%b want=11", mat_input_row_col, mat_output_row_col); end
        n_cmp++; if (out_valid !== 1'b0 || proc_start !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_ctrl got ov=%b ps=%b err=%b want 000", out_valid, proc_start, err); end
        n_cmp++; if (out_block !== 128'd0) begin n_err++; $display("FAIL rst_out_block got=%h want=0", out_block); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_order();
        logic [31:0] cols [4];
        int t;
        cols[0] = 32'h00112233; cols[1] = 32'h44556677;
        cols[2] = 32'h8899aabb; cols[3] = 32'hccddeeff;
        accept_block({cols[0], cols[1], cols[2], cols[3]});
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (mat_write_enable !== 1'b1) begin n_err++; $display("FAIL load_we[%0d] got=%b want=1", k, mat_write_enable); end
            n_cmp++; if (mat_input_idx !== 2'(k)) begin n_err++; $display("FAIL load_idx[%0d] got=%0d want=%0d", k, mat_input_idx, k); end
            n_cmp++; if (mat_col_in !== cols[k]) begin n_err++; $display("FAIL load_col[%0d] got=%h want=%h", k, mat_col_in, cols[k]); end
            n_cmp++; if (proc_start !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL load_ctrl[%0d] ps=%b rdy=%b want 00", k, proc_start, in_ready); end
            @(negedge clk);
        end
        n_cmp++; if (proc_start !== 1'b1) begin n_err++; $display("FAIL load_start got=%b want=1", proc_start); end
        n_cmp++; if (mat_write_enable !== 1'b0 || mat_col_in !== 32'd0) begin n_err++; $display("FAIL load_after we=%b col=%h want 0/0", mat_write_enable, mat_col_in); end
        @(negedge clk);
        n_cmp++; if (proc_start !== 1'b0) begin n_err++; $display("FAIL start_pulse got=%b want=0", proc_start); end
        proc_done = 1'b1;
        @(negedge clk);
        proc_done = 1'b0;
        t = 0;
        while (out_valid !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL load_drain out_valid=%b want=1", out_valid); end
        release_hold();
    endtask

    task automatic test_loopback();
        logic [127:0] b;
        int s, v;
        b = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        run_block(b, s, v);
        n_cmp++; if (s !== 5) begin n_err++; $display("FAIL loop_start_cycle got=%0d want=5", s); end
        n_cmp++; if (v !== 11) begin n_err++; $display("FAIL loop_latency got=%0d want=11", v); end
        n_cmp++; if (out_block !== b) begin n_err++; $display("FAIL loop_data got=%h want=%h", out_block, b); end
        n_cmp++; if (err !== 1'b0 || in_ready !== 1'b0) begin n_err++; $display("FAIL loop_flags err=%b rdy=%b want 00", err, in_ready); end
        release_hold();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL loop_release ov=%b rdy=%b want 01", out_valid, in_ready); end
        xor_mask = 32'ha5a55a5a;
        run_block(b, s, v);
        n_cmp++; if (out_block !== (b ^ {4{32'ha5a55a5a}})) begin n_err++; $display("FAIL loop_masked got=%h want=%h", out_block, b ^ {4{32'ha5a55a5a}}); end
        release_hold();
        xor_mask = 32'd0;
    endtask

    task automatic test_backpressure();
        logic [127:0] b;
        int s, v;
        b = 128'hdeadbeef_01234567_89abcdef_cafef00d;
        run_block(b, s, v);
        for (int i = 0; i < 12; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_block !== b) begin
                n_err++;
                $display("FAIL bp_hold[%0d] ov=%b rdy=%b blk=%h want 1/0/%h", i, out_valid, in_ready, out_block, b);
            end
            @(negedge clk);
        end
        release_hold();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release ov=%b rdy=%b want 01", out_valid, in_ready); end
    endtask

    task automatic test_done_masking();
        int v;
        logic [1:0] idx8, idx10;
        v = -1;
        idx8 = 2'd0;
        idx10 = 2'd0;
        proc_done = 1'b1;
        accept_block(128'h11111111_22222222_33333333_44444444);
        for (int n = 1; n <= 13; n++) begin
            if (n == 8)  idx8  = mat_output_idx;
            if (n == 10) idx10 = mat_output_idx;
            if (out_valid === 1'b1 && v < 0) v = n;
            @(negedge clk);
        end
        proc_done = 1'b0;
        n_cmp++; if (v !== 11) begin n_err++; $display("FAIL mask_latency got=%0d want=11", v); end
        n_cmp++; if (idx8 !== 2'd1 || idx10 !== 2'd3) begin n_err++; $display("FAIL mask_unload_idx got=%0d,%0d want=1,3", idx8, idx10); end
        n_cmp++; if (out_block !== 128'h11111111_22222222_33333333_44444444) begin n_err++; $display("FAIL mask_data got=%h", out_block); end
        release_hold();
    endtask

    task automatic test_timeout();
        int s, e, r, v;
        logic seen_valid;
        s = -1; e = -1; r = -1; seen_valid = 1'b0;
        accept_block(128'h55555555_66666666_77777777_88888888);
        for (int n = 1; n <= 20; n++) begin
            if (proc_start === 1'b1 && s < 0) s = n;
            if (err === 1'b1 && e < 0) e = n;
            if (s > 0 && in_ready === 1'b1 && r < 0) r = n;
            if (out_valid === 1'b1) seen_valid = 1'b1;
            @(negedge clk);
        end
        n_cmp++; if (e !== 14) begin n_err++; $display("FAIL to_err_cycle got=%0d want=14", e); end
        n_cmp++; if (r !== 14) begin n_err++; $display("FAIL to_idle_cycle got=%0d want=14", r); end
        n_cmp++; if (seen_valid !== 1'b0) begin n_err++; $display("FAIL to_out_valid got=%b want=0", seen_valid); end

        // Done arriving on the expiry cycle must complete the transfer and clear err.
        s = -1; v = -1;
        accept_block(128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc);
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL to_err_clear got=%b want=0", err); end
        for (int n = 1; n <= 20; n++) begin
            if (proc_start === 1'b1 && s < 0) s = n;
            proc_done = (s > 0 && n == s + 8);
            if (out_valid === 1'b1 && v < 0) v = n;
            @(negedge clk);
        end
        proc_done = 1'b0;
        n_cmp++; if (v !== 18 || err !== 1'b0) begin n_err++; $display("FAIL to_late_done valid_at=%0d err=%b want 18/0", v, err); end
        n_cmp++; if (out_block !== 128'h99999999_aaaaaaaa_bbbbbbbb_cccccccc) begin n_err++; $display("FAIL to_late_data got=%h", out_block); end
        release_hold();
    endtask

    task automatic test_reset_midload();
        logic [127:0] b;
        int s, v;
        accept_block(128'h01010101_02020202_03030303_04040404);
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mat_write_enable !== 1'b1 || mat_input_idx !== 2'd2) begin n_err++; $display("FAIL rl_pre we=%b idx=%0d want 1/2", mat_write_enable, mat_input_idx); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (mat_write_enable !== 1'b0 || mat_input_idx !== 2'd0 || mat_col_in !== 32'd0) begin n_err++; $display("FAIL rl_mat we=%b idx=%0d col=%h want 0/0/0", mat_write_enable, mat_input_idx, mat_col_in); end
        n_cmp++; if (in_ready !== 1'b1 || proc_start !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rl_ctrl rdy=%b ps=%b ov=%b err=%b want 1000", in_ready, proc_start, out_valid, err); end
        n_cmp++; if (out_block !== 128'd0) begin n_err++; $display("FAIL rl_out_block got=%h want=0", out_block); end
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        b = 128'hfedcba98_76543210_13579bdf_2468ace0;
        run_block(b, s, v);
        n_cmp++; if (v !== 11 || out_block !== b) begin n_err++; $display("FAIL rl_fresh valid_at=%0d blk=%h want 11/%h", v, out_block, b); end
        release_hold();
    endtask

    initial begin
        test_reset();
        test_load_order();
        test_loopback();
        test_backpressure();
        test_done_masking();
        test_timeout();
        test_reset_midload();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
